// File: rtl/adau_spi_if.sv
// Pin and register-port bundle for the ADAU control-port SPI responder.
// The master modport is the initiator/register-file side; slave is adau_spi_target.
interface adau_spi_if;
    logic        spi_clk;
    logic        spi_frame;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [7:0]  reg_rdata;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;

    modport master (
        output spi_clk, spi_frame, spi_mosi, reg_rdata,
        input  spi_miso, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
               busy, frame_done, frame_abort
    );

    modport slave (
        input  spi_clk, spi_frame, spi_mosi, reg_rdata,
        output spi_miso, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
               busy, frame_done, frame_abort
    );
endinterface

// File: rtl/adau_spi_target.sv
// SPI responder for the ADAU codec control port: header, 16-bit address, auto-incrementing data bytes.
// Define ADAU_SPI_TARGET_READ_EN to build the read path (reg_rd_en strobes and MISO shifting).
module adau_spi_target #(
    parameter logic [6:0]  DEVICE_ADDR     = 7'h00,
    parameter int unsigned MIN_HALF_PERIOD = 4
) (
    input  logic      clk,
    input  logic      reset,
    adau_spi_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR, ADDR, DATA, SKIP} state_t;

    // The tx byte is reloaded two cycles after the rise that completes a byte.
    if (MIN_HALF_PERIOD < 3) begin : g_half_period_check
        $error("adau_spi_target: MIN_HALF_PERIOD must be at least 3");
    end

    logic [2:0]  sclk_sync;
    logic [2:0]  frame_sync;
    logic [1:0]  mosi_sync;
    logic        sclk_rise;
    logic        frame_rise;
    logic        frame_fall;
    logic        mosi_s;

    state_t      state;
    state_t      state_next;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic [7:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic        rw;
    logic        active;
    logic        capture;
    logic        byte_done;
    logic        hdr_match;

    logic        busy_c;
    logic        wr_fire;
    logic        end_fire;
    logic        abort_fire;

    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        wr_en_q;
    logic        done_q;
    logic        abort_q;

`ifdef ADAU_SPI_TARGET_READ_EN
    logic        sclk_fall;
    logic        rd_fire;
    logic        rd_en_q;
    logic        rd_load;
    logic [7:0]  tx_sr;
    logic        miso_q;
`else
    logic        unused_rdata;
`endif

    // NOTE: frame sync resets low, so a frame already low at reset release never reads as a fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync  <= '0;
            frame_sync <= '0;
            mosi_sync  <= '0;
        end else begin
            sclk_sync  <= {sclk_sync[1:0], bus.spi_clk};
            frame_sync <= {frame_sync[1:0], bus.spi_frame};
            mosi_sync  <= {mosi_sync[0], bus.spi_mosi};
        end
    end

    assign sclk_rise  =  sclk_sync[1] & ~sclk_sync[2];
    assign frame_rise =  frame_sync[1] & ~frame_sync[2];
    assign frame_fall = ~frame_sync[1] &  frame_sync[2];
    assign mosi_s     =  mosi_sync[1];
`ifdef ADAU_SPI_TARGET_READ_EN
    assign sclk_fall  = ~sclk_sync[1] &  sclk_sync[2];
`endif

    // A rise coincident with the frame rise is dropped rather than counted.
    assign active    = (state == HDR) || (state == ADDR) || (state == DATA);
    assign capture   = active && sclk_rise && !frame_rise;
    assign byte_done = capture && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr[6:0], mosi_s};
    assign hdr_match = (rx_byte[7:1] == DEVICE_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (state != IDLE && frame_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (frame_fall) state_next = HDR;
                HDR: begin
                    if (byte_done) begin
`ifdef ADAU_SPI_TARGET_READ_EN
                        state_next = hdr_match ? ADDR : SKIP;
`else
                        state_next = (hdr_match && !rx_byte[0]) ? ADDR : SKIP;
`endif
                    end
                end
                ADDR: if (byte_done && byte_cnt == 8'd2) state_next = DATA;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        busy_c     = active;
        end_fire   = (state != IDLE) && frame_rise;
        abort_fire = end_fire && ((bit_cnt != 3'd0) || (state == HDR) || (state == ADDR));
        wr_fire    = byte_done && (state == DATA) && !rw;
`ifdef ADAU_SPI_TARGET_READ_EN
        rd_fire    = byte_done && rw &&
                     ((state == DATA) || (state == ADDR && byte_cnt == 8'd2));
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_sr    <= '0;
            rw       <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
`ifdef ADAU_SPI_TARGET_READ_EN
            rd_en_q  <= 1'b0;
            rd_load  <= 1'b0;
            tx_sr    <= '0;
            miso_q   <= 1'b0;
`endif
        end else begin
            wr_en_q <= wr_fire;
            done_q  <= end_fire;
            abort_q <= abort_fire;

            if (state == IDLE && frame_fall) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (capture) begin
                rx_sr   <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7 && byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
            end

            if (byte_done && state == HDR) rw <= rx_byte[0];
            if (byte_done && state == ADDR) begin
                if (byte_cnt == 8'd1)      addr_q[15:8] <= rx_byte;
                else if (byte_cnt == 8'd2) addr_q[7:0]  <= rx_byte;
            end

            if (wr_fire) wdata_q <= rx_byte;
            // The address advances on the edge that ends the strobe, wrapping at 0xFFFF.
            if (wr_en_q) addr_q <= addr_q + 16'd1;

`ifdef ADAU_SPI_TARGET_READ_EN
            rd_en_q <= rd_fire;
            rd_load <= rd_en_q;
            if (state != DATA || !rw || frame_rise) begin
                miso_q <= 1'b0;
            end else if (sclk_fall) begin
                miso_q <= tx_sr[7];
                tx_sr  <= {tx_sr[6:0], 1'b0};
            end
            if (rd_load) begin
                tx_sr  <= bus.reg_rdata;
                addr_q <= addr_q + 16'd1;
            end
`endif
        end
    end

    assign bus.reg_addr    = addr_q;
    assign bus.reg_wdata   = wdata_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.busy        = busy_c;
    assign bus.frame_done  = done_q;
    assign bus.frame_abort = abort_q;
`ifdef ADAU_SPI_TARGET_READ_EN
    assign bus.reg_rd_en   = rd_en_q;
    assign bus.spi_miso    = miso_q;
`else
    assign bus.reg_rd_en   = 1'b0;
    assign bus.spi_miso    = 1'b0;
    assign unused_rdata    = ^bus.reg_rdata;
`endif
endmodule
